// File: rtl/osd_cmd_sequencer.sv
// osd_cmd_sequencer
// Buffers MCU/SPI command words in a FIFO and presents each one on
// osd_command for HOLD_CYCLES clk_bus cycles. Because the overlay only reacts
// to a change of osd_command, a word equal to the one currently driven is
// preceded by a separator word (16'h0000, or 16'h0001 if 16'h0000 is driven).
//
// Build option: define OSD_CMD_SEQ_FLUSH_EN so that a written word with
// opcode 8'hFF empties the FIFO instead of being queued.
//
// state      | meaning
// -----------+-------------------------------------------------------------
// S_IDLE     | waiting for a queued word; decides command vs. separator
// S_HOLD     | holding a popped command word on osd_command
// S_HOLD_SEP | holding a separator; head word stays queued for next IDLE
module osd_cmd_sequencer #(
  parameter int DEPTH_LOG2  = 4,
  parameter int HOLD_CYCLES = 4
) (
  input  logic        clk_bus,
  input  logic        areset_n,
  input  logic [15:0] wr_data,
  input  logic        wr_stb,
  output logic        full,
  output logic        empty,
  output logic        overflow,
  input  logic        clr_overflow,
  output logic        busy,
  output logic [15:0] osd_command
);

  localparam int                DEPTH     = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0] FULL_CNT = (DEPTH_LOG2+1)'(DEPTH);
  localparam logic [7:0]        HOLD_LOAD = 8'(HOLD_CYCLES - 1);

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_HOLD     = 2'd1,
    S_HOLD_SEP = 2'd2
  } state_t;

  state_t                r_state;
  state_t                w_state_nxt;
  logic [7:0]            r_hold_cnt;
  logic [7:0]            w_hold_cnt_nxt;
  logic [15:0]           r_cmd;
  logic [15:0]           w_cmd_nxt;

  logic [15:0]           r_mem [DEPTH];
  logic [DEPTH_LOG2-1:0] r_wr_ptr;
  logic [DEPTH_LOG2-1:0] r_rd_ptr;
  logic [DEPTH_LOG2:0]   r_count;
  logic                  r_overflow;

  logic                  w_full;
  logic                  w_empty;
  logic                  w_flush;
  logic                  w_push;
  logic                  w_drop;
  logic                  w_pop;
  logic [15:0]           w_head;
  logic [15:0]           w_sep;

`ifdef OSD_CMD_SEQ_FLUSH_EN
  assign w_flush = wr_stb && (wr_data[15:8] == 8'hFF);
`else
  assign w_flush = 1'b0;
`endif

  // full is taken from the registered count, so a same-cycle pop cannot make room for a write
  assign w_full  = (r_count == FULL_CNT);
  assign w_empty = (r_count == '0);
  assign w_push  = wr_stb && !w_flush && !w_full;
  assign w_drop  = wr_stb && !w_flush && w_full;
  assign w_head  = r_mem[r_rd_ptr];
  assign w_sep   = (r_cmd != 16'h0000) ? 16'h0000 : 16'h0001;

  // FIFO storage write port (no reset needed; validity tracked by r_count)
  always_ff @(posedge clk_bus) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= wr_data;
    end
  end

  // FIFO pointers and occupancy; a flush word clears them on its edge
  always_ff @(posedge clk_bus or negedge areset_n) begin
    if (!areset_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (w_flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      if (w_push && !w_pop) begin
        r_count <= r_count + 1'b1;
      end else if (!w_push && w_pop) begin
        r_count <= r_count - 1'b1;
      end
    end
  end

  // Sticky overflow flag; a dropped write wins over a same-cycle clear
  always_ff @(posedge clk_bus or negedge areset_n) begin
    if (!areset_n) begin
      r_overflow <= 1'b0;
    end else if (w_drop) begin
      r_overflow <= 1'b1;
    end else if (clr_overflow) begin
      r_overflow <= 1'b0;
    end
  end

  // Sequencer state, hold timer and output word registers
  always_ff @(posedge clk_bus or negedge areset_n) begin
    if (!areset_n) begin
      r_state    <= S_IDLE;
      r_hold_cnt <= '0;
      r_cmd      <= 16'h0000;
    end else begin
      r_state    <= w_state_nxt;
      r_hold_cnt <= w_hold_cnt_nxt;
      r_cmd      <= w_cmd_nxt;
    end
  end

  // Next-state logic: emit head word, or a separator when the head repeats osd_command
  always_comb begin
    w_state_nxt    = r_state;
    w_hold_cnt_nxt = r_hold_cnt;
    w_cmd_nxt      = r_cmd;
    w_pop          = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (!w_empty) begin
          w_hold_cnt_nxt = HOLD_LOAD;
          if (w_head != r_cmd) begin
            w_pop       = 1'b1;
            w_cmd_nxt   = w_head;
            w_state_nxt = S_HOLD;
          end else begin
            w_cmd_nxt   = w_sep;
            w_state_nxt = S_HOLD_SEP;
          end
        end
      end
      S_HOLD, S_HOLD_SEP: begin
        if (r_hold_cnt == 8'd0) begin
          w_state_nxt = S_IDLE;
        end else begin
          w_hold_cnt_nxt = r_hold_cnt - 8'd1;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  assign full        = w_full;
  assign empty       = w_empty;
  assign overflow    = r_overflow;
  assign busy        = !w_empty || (r_state != S_IDLE);
  assign osd_command = r_cmd;

endmodule

// File: tb/tb_osd_cmd_sequencer.sv
// Testbench for osd_cmd_sequencer: vector table, hand-written corner
// sequences and randomized traffic against a queue-based reference model.
module tb_osd_cmd_sequencer;

  localparam int HOLD  = 4;
  localparam int DEPTH = 16;

  logic        clk_bus = 1'b0;
  logic        areset_n = 1'b0;
  logic [15:0] wr_data = 16'h0000;
  logic        wr_stb = 1'b0;
  logic        clr_overflow = 1'b0;
  logic        full, empty, overflow, busy;
  logic [15:0] osd_command;

  osd_cmd_sequencer #(.DEPTH_LOG2(4), .HOLD_CYCLES(HOLD)) dut (
    .clk_bus      (clk_bus),
    .areset_n     (areset_n),
    .wr_data      (wr_data),
    .wr_stb       (wr_stb),
    .full         (full),
    .empty        (empty),
    .overflow     (overflow),
    .clr_overflow (clr_overflow),
    .busy         (busy),
    .osd_command  (osd_command)
  );

  always #5 clk_bus = ~clk_bus;

  int checks = 0;
  int errors = 0;

  // Reference model: a word queue plus "cycles until the next emission decision"
  logic [15:0] mq[$];
  logic [15:0] m_cmd;
  int          m_wait;
  logic        m_ovf;
  int          cyc;
  int          last_change;
  logic [15:0] prev_cmd;

  typedef struct {
    logic        wr;
    logic [15:0] data;
    logic        clr;
    logic [15:0] e_cmd;
    logic        e_full;
    logic        e_empty;
    logic        e_ovf;
    logic        e_busy;
  } vec_t;

  vec_t tbl[18];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s @cyc %0d: got %h expected %h", name, cyc, act, exp);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    m_cmd       = 16'h0000;
    m_wait      = 0;
    m_ovf       = 1'b0;
    last_change = -1000;
    prev_cmd    = 16'h0000;
  endtask

  task automatic model_edge(input logic w, input logic [15:0] d, input logic c);
    bit full_pre;
    bit flush;
    bit dropped;
    full_pre = (mq.size() == DEPTH);
    flush    = 1'b0;
`ifdef OSD_CMD_SEQ_FLUSH_EN
    flush = w && (d[15:8] == 8'hFF);
`endif
    if (m_wait > 0) begin
      m_wait--;
    end else if (mq.size() > 0) begin
      if (mq[0] != m_cmd) m_cmd = mq.pop_front();
      else                m_cmd = (m_cmd != 16'h0000) ? 16'h0000 : 16'h0001;
      m_wait = HOLD;
    end
    dropped = w && !flush && full_pre;
    if (flush)          mq.delete();
    else if (w && !full_pre) mq.push_back(d);
    if (dropped)        m_ovf = 1'b1;
    else if (c)         m_ovf = 1'b0;
  endtask

  task automatic compare_model();
    check("osd_command", 32'(osd_command), 32'(m_cmd));
    check("full",        32'(full),        32'(mq.size() == DEPTH));
    check("empty",       32'(empty),       32'(mq.size() == 0));
    check("overflow",    32'(overflow),    32'(m_ovf));
    check("busy",        32'(busy),        32'((mq.size() != 0) || (m_wait != 0)));
    if (osd_command !== prev_cmd) begin
      check("min_stable", 32'((cyc - last_change) >= HOLD), 32'd1);
      last_change = cyc;
      prev_cmd    = osd_command;
    end
  endtask

  task automatic step(input logic w, input logic [15:0] d, input logic c);
    wr_stb       = w;
    wr_data      = d;
    clr_overflow = c;
    @(posedge clk_bus);
    model_edge(w, d, c);
    #1;
    cyc++;
    compare_model();
    wr_stb       = 1'b0;
    clr_overflow = 1'b0;
  endtask

  task automatic check_reset(input string tag);
    check({tag, "_osd"},   32'(osd_command), 32'h0000);
    check({tag, "_full"},  32'(full),        32'd0);
    check({tag, "_empty"}, 32'(empty),       32'd1);
    check({tag, "_ovf"},   32'(overflow),    32'd0);
    check({tag, "_busy"},  32'(busy),        32'd0);
  endtask

  task automatic do_reset();
    areset_n = 1'b0;
    model_reset();
    #3;
    check_reset("reset");
    repeat (2) @(negedge clk_bus);
    areset_n = 1'b1;
  endtask

  logic [15:0] seen[$];
  int          chg_cyc[$];
  logic [15:0] last_seen;

  task automatic log_change();
    if (osd_command !== last_seen) begin
      seen.push_back(osd_command);
      chg_cyc.push_back(cyc);
      last_seen = osd_command;
    end
  endtask

  initial begin
    int rate;
    int k;
    logic [15:0] lastw;
    logic [15:0] d;
    logic [15:0] exp_rep[5];

    // wr, data, clr, exp osd, full, empty, ovf, busy
    tbl[0]  = '{1'b1, 16'h0000, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b1};
    tbl[1]  = '{1'b0, 16'h0000, 1'b0, 16'h0001, 1'b0, 1'b0, 1'b0, 1'b1};
    tbl[2]  = '{1'b0, 16'h0000, 1'b0, 16'h0001, 1'b0, 1'b0, 1'b0, 1'b1};
    tbl[3]  = '{1'b0, 16'h0000, 1'b0, 16'h0001, 1'b0, 1'b0, 1'b0, 1'b1};
    tbl[4]  = '{1'b0, 16'h0000, 1'b0, 16'h0001, 1'b0, 1'b0, 1'b0, 1'b1};
    tbl[5]  = '{1'b0, 16'h0000, 1'b0, 16'h0001, 1'b0, 1'b0, 1'b0, 1'b1};
    tbl[6]  = '{1'b0, 16'h0000, 1'b0, 16'h0000, 1'b0, 1'b1, 1'b0, 1'b1};
    tbl[7]  = '{1'b0, 16'h0000, 1'b0, 16'h0000, 1'b0, 1'b1, 1'b0, 1'b1};
    tbl[8]  = '{1'b0, 16'h0000, 1'b0, 16'h0000, 1'b0, 1'b1, 1'b0, 1'b1};
    tbl[9]  = '{1'b0, 16'h0000, 1'b0, 16'h0000, 1'b0, 1'b1, 1'b0, 1'b1};
    tbl[10] = '{1'b0, 16'h0000, 1'b0, 16'h0000, 1'b0, 1'b1, 1'b0, 1'b0};
    tbl[11] = '{1'b0, 16'h0000, 1'b1, 16'h0000, 1'b0, 1'b1, 1'b0, 1'b0};
    tbl[12] = '{1'b1, 16'h0101, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b1};
    tbl[13] = '{1'b0, 16'h0000, 1'b0, 16'h0101, 1'b0, 1'b1, 1'b0, 1'b1};
    tbl[14] = '{1'b0, 16'h0000, 1'b0, 16'h0101, 1'b0, 1'b1, 1'b0, 1'b1};
    tbl[15] = '{1'b0, 16'h0000, 1'b0, 16'h0101, 1'b0, 1'b1, 1'b0, 1'b1};
    tbl[16] = '{1'b0, 16'h0000, 1'b0, 16'h0101, 1'b0, 1'b1, 1'b0, 1'b1};
    tbl[17] = '{1'b0, 16'h0000, 1'b0, 16'h0101, 1'b0, 1'b1, 1'b0, 1'b0};

    cyc = 0;
    do_reset();

    // Vector table: 0000 as first word (separator 0001), then a single 0101
    for (int i = 0; i < 18; i++) begin
      step(tbl[i].wr, tbl[i].data, tbl[i].clr);
      check($sformatf("tbl%0d_osd", i),   32'(osd_command), 32'(tbl[i].e_cmd));
      check($sformatf("tbl%0d_full", i),  32'(full),        32'(tbl[i].e_full));
      check($sformatf("tbl%0d_empty", i), 32'(empty),       32'(tbl[i].e_empty));
      check($sformatf("tbl%0d_ovf", i),   32'(overflow),    32'(tbl[i].e_ovf));
      check($sformatf("tbl%0d_busy", i),  32'(busy),        32'(tbl[i].e_busy));
    end

    // Three identical words back to back: separators keep every repeat visible
    seen.delete(); chg_cyc.delete(); last_seen = osd_command;
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 16'h2155, 1'b0);
      log_change();
    end
    k = 0;
    while (!(seen.size() >= 5 && !busy) && k < 60) begin
      step(1'b0, 16'h0000, 1'b0);
      log_change();
      k++;
    end
    exp_rep[0] = 16'h2155; exp_rep[1] = 16'h0000; exp_rep[2] = 16'h2155;
    exp_rep[3] = 16'h0000; exp_rep[4] = 16'h2155;
    check("rep_count", 32'(seen.size()), 32'd5);
    for (int i = 0; i < 5 && i < seen.size(); i++) begin
      check($sformatf("rep_val%0d", i), 32'(seen[i]), 32'(exp_rep[i]));
      if (i > 0) check($sformatf("rep_gap%0d", i), 32'(chg_cyc[i] - chg_cyc[i-1]), 32'(HOLD + 1));
    end
    repeat (2) step(1'b0, 16'h0000, 1'b0);

    // Fill to full while draining; writes at the 21st and 22nd edges are dropped
    seen.delete(); chg_cyc.delete(); last_seen = osd_command;
    for (int i = 0; i < 23; i++) begin
      step(1'b1, 16'h1000 + 16'(i), 1'b0);
      log_change();
      if (i == 19) check("fill_full_after20", 32'(full), 32'd1);
      if (i == 19) check("fill_ovf_after20", 32'(overflow), 32'd0);
      if (i == 20) check("fill_ovf_after21", 32'(overflow), 32'd1);
      if (i == 21) check("fill_notfull_after_pop", 32'(full), 32'd0);
      if (i == 22) check("fill_full_after23", 32'(full), 32'd1);
    end
    step(1'b0, 16'h0000, 1'b0);
    log_change();
    check("ovf_sticky", 32'(overflow), 32'd1);
    step(1'b0, 16'h0000, 1'b1);
    log_change();
    check("ovf_cleared", 32'(overflow), 32'd0);
    k = 0;
    while (busy && k < 200) begin
      step(1'b0, 16'h0000, 1'b0);
      log_change();
      k++;
    end
    check("fill_drained", 32'(busy), 32'd0);
    check("fill_emit_count", 32'(seen.size()), 32'd21);
    for (int i = 0; i < 21 && i < seen.size(); i++) begin
      d = (i < 20) ? 16'h1000 + 16'(i) : 16'h1016;
      check($sformatf("fill_order%0d", i), 32'(seen[i]), 32'(d));
    end

    // Asynchronous reset in the middle of a HOLD with five words queued
    for (int i = 0; i < 7; i++) step(1'b1, 16'h2000 + 16'(i), 1'b0);
    step(1'b0, 16'h0000, 1'b0);
    check("midhold_queued", 32'(mq.size()), 32'd5);
    check("midhold_osd", 32'(osd_command), 32'h2001);
    #2;
    areset_n = 1'b0;
    model_reset();
    #1;
    check_reset("async_rst");
    repeat (2) @(negedge clk_bus);
    areset_n = 1'b1;
    for (int i = 0; i < 20; i++) step(1'b0, 16'h0000, 1'b0);
    check("post_rst_osd", 32'(osd_command), 32'h0000);

`ifdef OSD_CMD_SEQ_FLUSH_EN
    // Flush during the first word's hold: rest of the queue vanishes
    for (int i = 0; i < 3; i++) step(1'b1, 16'h3000 + 16'(i), 1'b0);
    step(1'b1, 16'hFF00, 1'b0);
    check("flush_empty", 32'(empty), 32'd1);
    for (int i = 0; i < 15; i++) step(1'b0, 16'h0000, 1'b0);
    check("flush_osd_kept", 32'(osd_command), 32'h3000);
    check("flush_idle", 32'(busy), 32'd0);
`endif

    // Randomized traffic against the reference model
    do_reset();
    lastw = 16'h0000;
    rate  = 30;
    for (int i = 0; i < 3000; i++) begin
      if (i % 200 == 0) begin
        case ($urandom_range(0, 3))
          0: rate = 10;
          1: rate = 30;
          2: rate = 60;
          default: rate = 95;
        endcase
      end
      case ($urandom_range(0, 7))
        0: d = 16'h0000;
        1: d = 16'h0001;
        2: d = 16'h2155;
        3: d = 16'h1313;
        4: d = lastw;
        5: d = {8'hFF, 8'($urandom_range(0, 255))};
        default: d = 16'($urandom);
      endcase
      if ($urandom_range(0, 99) < rate) begin
        lastw = d;
        step(1'b1, d, ($urandom_range(0, 19) == 0));
      end else begin
        step(1'b0, d, ($urandom_range(0, 19) == 0));
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
